// File: rtl/decode_pkg.sv
// decode_pkg: RV32I opcode constants, selector enums and the decoded control word
package decode_pkg;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  typedef enum logic [2:0] {
    ALUOP_ADD, ALUOP_SLL, ALUOP_SLT, ALUOP_SLTU, ALUOP_XOR, ALUOP_SRL, ALUOP_OR, ALUOP_AND
  } alu_op_t;
  typedef enum logic [1:0] {SRC1_RS1, SRC1_PC, SRC1_ZERO} src1_sel_t;
  typedef enum logic [1:0] {SRC2_RS2, SRC2_IMM, SRC2_FOUR} src2_sel_t;
  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SH} imm_fmt_t;
  typedef struct packed {
    alu_op_t    alu_op;
    logic       alu_alt;
    src1_sel_t  src1_sel;
    src2_sel_t  src2_sel;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       reg_write;
    logic       branch;
    logic [2:0] branch_cond;
    logic       jump;
    logic       jump_reg;
    logic       load;
    logic       store;
    logic [2:0] mem_width;
    logic       illegal;
  } decoded_t;
endpackage

// File: rtl/decode_stage_imm_gen.sv
// decode_stage_imm_gen: builds the 32-bit immediate of an RV32I instruction for a given format
module decode_stage_imm_gen
  import decode_pkg::*;
(
  input  logic [31:7] instr,
  input  imm_fmt_t    fmt,
  output logic [31:0] imm
);
  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_SH:  imm = {27'b0, instr[24:20]};
      default: imm = '0;
    endcase
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode pipeline stage registering the control word behind a valid/ready handshake
module decode_stage
  import decode_pkg::*;
(
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Flush,
  input  logic        i_FetchValid,
  input  logic [31:0] i_FetchInstr,
  input  logic [31:0] i_FetchPC,
  output logic        o_FetchReady,
  output logic        o_DecValid,
  input  logic        i_ExecReady,
  output logic [31:0] o_PC,
  output logic [2:0]  o_AluOp,
  output logic        o_AluOpAlt,
  output logic [1:0]  o_Src1Sel,
  output logic [1:0]  o_Src2Sel,
  output logic [4:0]  o_Rs1,
  output logic [4:0]  o_Rs2,
  output logic [4:0]  o_Rd,
  output logic [31:0] o_Imm,
  output logic        o_RegWrite,
  output logic        o_Branch,
  output logic [2:0]  o_BranchCond,
  output logic        o_Jump,
  output logic        o_JumpReg,
  output logic        o_Load,
  output logic        o_Store,
  output logic [2:0]  o_MemWidth,
  output logic        o_Illegal
);
  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;
  decoded_t dec, dec_d, dec_q;
  imm_fmt_t fmt;
  logic legal;
  logic [31:0] imm, imm_d, imm_q;
  logic [31:0] pc_d, pc_q;
  logic valid_d, valid_q;
  logic fire, load;
  assign opc = i_FetchInstr[6:0];
  assign f3  = i_FetchInstr[14:12];
  assign f7  = i_FetchInstr[31:25];
  assign rs1 = i_FetchInstr[19:15];
  assign rs2 = i_FetchInstr[24:20];
  assign rd  = i_FetchInstr[11:7];
  decode_stage_imm_gen u_imm_gen (
    .instr(i_FetchInstr[31:7]),
    .fmt  (fmt),
    .imm  (imm)
  );
  always_comb begin
    dec = '0;
    fmt = IMM_NONE;
    legal = 1'b0;
    case (opc)
      OPC_OP: begin
        legal = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
        dec.alu_op = alu_op_t'(f3);
        dec.alu_alt = f7[5];
        dec.rs1 = rs1;
        dec.rs2 = rs2;
        dec.rd = rd;
        dec.reg_write = 1'b1;
      end
      OPC_OPIMM: begin
        legal = f3 == 3'b001 ? f7 == 7'h00 : (f3 != 3'b101 || f7 == 7'h00 || f7 == 7'h20);
        dec.alu_op = alu_op_t'(f3);
        dec.alu_alt = f3 == 3'b101 && f7[5];
        dec.src2_sel = SRC2_IMM;
        dec.rs1 = rs1;
        dec.rd = rd;
        dec.reg_write = 1'b1;
        fmt = f3[1:0] == 2'b01 ? IMM_SH : IMM_I;
      end
      OPC_LUI, OPC_AUIPC: begin
        legal = 1'b1;
        dec.src1_sel = opc == OPC_LUI ? SRC1_ZERO : SRC1_PC;
        dec.src2_sel = SRC2_IMM;
        dec.rd = rd;
        dec.reg_write = 1'b1;
        fmt = IMM_U;
      end
      OPC_JAL, OPC_JALR: begin
        legal = opc == OPC_JAL || f3 == 3'b000;
        dec.src1_sel = SRC1_PC;
        dec.src2_sel = SRC2_FOUR;
        dec.rs1 = opc == OPC_JALR ? rs1 : 5'd0;
        dec.rd = rd;
        dec.reg_write = 1'b1;
        dec.jump = 1'b1;
        dec.jump_reg = opc == OPC_JALR;
        fmt = opc == OPC_JAL ? IMM_J : IMM_I;
      end
      OPC_LOAD: begin
        legal = f3[1:0] != 2'b11 && f3 != 3'b110;
        dec.src2_sel = SRC2_IMM;
        dec.rs1 = rs1;
        dec.rd = rd;
        dec.reg_write = 1'b1;
        dec.load = 1'b1;
        dec.mem_width = f3;
        fmt = IMM_I;
      end
      OPC_STORE: begin
        legal = !f3[2] && f3[1:0] != 2'b11;
        dec.src2_sel = SRC2_IMM;
        dec.rs1 = rs1;
        dec.rs2 = rs2;
        dec.store = 1'b1;
        dec.mem_width = f3;
        fmt = IMM_S;
      end
      OPC_BRANCH: begin
        legal = f3[2:1] != 2'b01;
        dec.alu_op = f3[2] ? (f3[1] ? ALUOP_SLTU : ALUOP_SLT) : ALUOP_ADD;
        dec.alu_alt = !f3[2];
        dec.rs1 = rs1;
        dec.rs2 = rs2;
        dec.branch = 1'b1;
        dec.branch_cond = f3;
        fmt = IMM_B;
      end
      default: legal = 1'b0;
    endcase
    dec.reg_write = dec.reg_write && rd != 5'd0;
    if (!legal) begin
      dec = '0;
      dec.illegal = 1'b1;
      fmt = IMM_NONE;
    end
  end
  assign o_FetchReady = !valid_q || i_ExecReady;
  assign fire = i_FetchValid && o_FetchReady;
  always_comb begin
    load = fire && !i_Flush;
    valid_d = i_Flush ? 1'b0 : fire || (valid_q && !i_ExecReady);
    dec_d = load ? dec : dec_q;
    imm_d = load ? imm : imm_q;
    pc_d = load ? i_FetchPC : pc_q;
  end
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      valid_q <= 1'b0;
      dec_q <= '0;
      imm_q <= '0;
      pc_q <= '0;
    end else begin
      valid_q <= valid_d;
      dec_q <= dec_d;
      imm_q <= imm_d;
      pc_q <= pc_d;
    end
  end
  assign o_DecValid   = valid_q;
  assign o_PC         = pc_q;
  assign o_AluOp      = dec_q.alu_op;
  assign o_AluOpAlt   = dec_q.alu_alt;
  assign o_Src1Sel    = dec_q.src1_sel;
  assign o_Src2Sel    = dec_q.src2_sel;
  assign o_Rs1        = dec_q.rs1;
  assign o_Rs2        = dec_q.rs2;
  assign o_Rd         = dec_q.rd;
  assign o_Imm        = imm_q;
  assign o_RegWrite   = dec_q.reg_write;
  assign o_Branch     = dec_q.branch;
  assign o_BranchCond = dec_q.branch_cond;
  assign o_Jump       = dec_q.jump;
  assign o_JumpReg    = dec_q.jump_reg;
  assign o_Load       = dec_q.load;
  assign o_Store      = dec_q.store;
  assign o_MemWidth   = dec_q.mem_width;
  assign o_Illegal    = dec_q.illegal;
endmodule
